// File: rtl/mem_mux_if.sv
// Bundle of the two requester ports plus the BRAM command/data lines.
// slave = the mux's view, master = the requesters' and memory's view.
interface mem_mux_if #(
   parameter int ADDR_W = 16
);
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [31:0]       a_wdata;
   logic              a_ack;
   logic              a_rvalid;
   logic [31:0]       a_rdata;
   logic              a_err;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [31:0]       b_wdata;
   logic              b_ack;
   logic              b_rvalid;
   logic [31:0]       b_rdata;
   logic              b_err;

   logic [1:0]        mem_cmd;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wr_data;
   logic [31:0]       mem_rd_data;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      input  b_req, b_we, b_addr, b_wdata,
      input  mem_rd_data,
      output a_ack, a_rvalid, a_rdata, a_err,
      output b_ack, b_rvalid, b_rdata, b_err,
      output mem_cmd, mem_addr, mem_wr_data
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      output b_req, b_we, b_addr, b_wdata,
      output mem_rd_data,
      input  a_ack, a_rvalid, a_rdata, a_err,
      input  b_ack, b_rvalid, b_rdata, b_err,
      input  mem_cmd, mem_addr, mem_wr_data
   );
endinterface

// File: rtl/mem_mux.sv
// Two-port round-robin arbiter in front of a single-port word BRAM.
// One memory operation in flight; out-of-range accesses are acked with err and never reach memory.
//   state   | meaning
//   IDLE    | waiting for a request; grant happens on the edge leaving IDLE
//   ISSUE   | ack + err pulse, mem_cmd driven for in-range accesses
//   CAPTURE | read only: mem_rd_data is valid, latched into the granted port on exit
module mem_mux #(
   parameter int          ADDR_W = 16,
   parameter int unsigned DEPTH  = 32'h8820
) (
   input  logic      clk,
   input  logic      rst,
   mem_mux_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   localparam logic [1:0]        CMD_IDLE = 2'b00;
   localparam logic [1:0]        CMD_RD   = 2'b01;
   localparam logic [1:0]        CMD_WR   = 2'b10;
   localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);

   state_t state;
   logic   cap_we;
   logic   cap_port;     // 0 = A, 1 = B
   logic   cap_oor;
   logic   last_grant;   // 0 = A, 1 = B

   logic              grant_b;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic              sel_oor;

   // B wins when it is alone, or on a tie when A was granted last.
   assign grant_b   = bus.b_req && (!bus.a_req || !last_grant);
   assign sel_we    = grant_b ? bus.b_we    : bus.a_we;
   assign sel_addr  = grant_b ? bus.b_addr  : bus.a_addr;
   assign sel_wdata = grant_b ? bus.b_wdata : bus.a_wdata;
   assign sel_oor   = {1'b0, sel_addr} >= DEPTH_L;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         cap_we          <= 1'b0;
         cap_port        <= 1'b0;
         cap_oor         <= 1'b0;
         last_grant      <= 1'b1;
         bus.mem_cmd     <= CMD_IDLE;
         bus.mem_addr    <= '0;
         bus.mem_wr_data <= '0;
         bus.a_ack       <= 1'b0;
         bus.b_ack       <= 1'b0;
         bus.a_err       <= 1'b0;
         bus.b_err       <= 1'b0;
         bus.a_rvalid    <= 1'b0;
         bus.b_rvalid    <= 1'b0;
         bus.a_rdata     <= '0;
         bus.b_rdata     <= '0;
      end else begin
         bus.a_ack    <= 1'b0;
         bus.b_ack    <= 1'b0;
         bus.a_err    <= 1'b0;
         bus.b_err    <= 1'b0;
         bus.a_rvalid <= 1'b0;
         bus.b_rvalid <= 1'b0;
         bus.mem_cmd  <= CMD_IDLE;
         case (state)
            IDLE: begin
               if (bus.a_req || bus.b_req) begin
                  cap_we          <= sel_we;
                  cap_port        <= grant_b;
                  cap_oor         <= sel_oor;
                  last_grant      <= grant_b;
                  bus.mem_addr    <= sel_addr;
                  bus.mem_wr_data <= sel_wdata;
                  if (!sel_oor)
                     bus.mem_cmd  <= sel_we ? CMD_WR : CMD_RD;
                  bus.a_ack       <= !grant_b;
                  bus.b_ack       <= grant_b;
                  bus.a_err       <= !grant_b && sel_oor;
                  bus.b_err       <= grant_b && sel_oor;
                  state           <= ISSUE;
               end
            end
            ISSUE: begin
               state <= cap_we ? IDLE : CAPTURE;
            end
            CAPTURE: begin
               // Out-of-range reads never issued a command, so return zero instead of bus noise.
               if (cap_port) begin
                  bus.b_rdata  <= cap_oor ? 32'h0 : bus.mem_rd_data;
                  bus.b_rvalid <= 1'b1;
               end else begin
                  bus.a_rdata  <= cap_oor ? 32'h0 : bus.mem_rd_data;
                  bus.a_rvalid <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
